indirect_master: RTL

- Initiator for the team's two-register indirect access window: an ADDR register at BASE_ADDR+REG_ADDR_OFFSET and a DATA register at BASE_ADDR+REG_DATA_OFFSET.
- Accepts single read/write commands on a valid/ready interface.
- Converts each command into the register-bus sequence: write ADDR, then write or read DATA. Returns a one-cycle response.
- Sits on the host side of the register bus, e.g. behind a debug UART or a DMA engine.

---
 rtl/indirect_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/indirect_master.sv
// Register-bus initiator for the two-register indirect window: ADDR write, then DATA write or read.
// Optional INDIRECT_MASTER_ADDR_CACHE_EN skips the ADDR write when the indirect address repeats.
module indirect_master #(
  parameter int                   ADDR_BITS       = 32,
  parameter int                   DATA_BITS       = 32,
  parameter int                   BE_BITS         = DATA_BITS / 8,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR       = '0,
  parameter logic [7:0]           REG_ADDR_OFFSET = 8'h0,
  parameter logic [7:0]           REG_DATA_OFFSET = 8'h4,
  parameter int                   RD_LATENCY      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [DATA_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_din,
  output logic [BE_BITS-1:0]   wr_be,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [DATA_BITS-1:0] rd_dout
);
  // state | meaning
  // IDLE  | ready for a command
  // WADDR | writing the indirect address into the ADDR register
  // WDATA | writing the latched data into the DATA register
  // RDATA | read strobe on the DATA register
  // RWAIT | waiting out the read latency, then sampling rd_dout
  // RESP  | one-cycle response pulse
  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_RDATA, S_RWAIT, S_RESP} state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_REG = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(REG_ADDR_OFFSET);
  localparam logic [ADDR_BITS-1:0] DATA_REG = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(REG_DATA_OFFSET);
  localparam logic [1:0]           CNT_LOAD = 2'(RD_LATENCY - 1);

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [DATA_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 busy_q, busy_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_din_q, wr_din_d;
  logic [BE_BITS-1:0]   wr_be_q, wr_be_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_en_q, rd_en_d;
  logic                 cache_hit;

`ifdef INDIRECT_MASTER_ADDR_CACHE_EN
  logic [DATA_BITS-1:0] last_addr_q, last_addr_d;
  logic                 cache_valid_q, cache_valid_d;

  always_comb begin
    last_addr_d   = last_addr_q;
    cache_valid_d = cache_valid_q;
    if (state_q == S_WADDR) begin
      last_addr_d   = addr_q;
      cache_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q   <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      last_addr_q   <= last_addr_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  assign cache_hit = cache_valid_q && (cmd_addr == last_addr_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = '0;
    rsp_valid_d = 1'b0;
    wr_addr_d   = '0;
    wr_din_d    = '0;
    wr_be_d     = '0;
    wr_en_d     = 1'b0;
    rd_addr_d   = '0;
    rd_en_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cache_hit) state_d = cmd_write ? S_WDATA : S_RDATA;
          else           state_d = S_WADDR;
        end
      end
      S_WADDR: state_d = write_q ? S_WDATA : S_RDATA;
      S_WDATA: state_d = S_RESP;
      S_RDATA: begin
        state_d = S_RWAIT;
        cnt_d   = CNT_LOAD;
      end
      S_RWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          rsp_rdata_d = rd_dout;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      S_WADDR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_REG;
        wr_din_d  = addr_d;
        wr_be_d   = '1;
      end
      S_WDATA: begin
        wr_en_d   = 1'b1;
        wr_addr_d = DATA_REG;
        wr_din_d  = wdata_d;
        wr_be_d   = '1;
      end
      S_RDATA: begin
        rd_en_d   = 1'b1;
        rd_addr_d = DATA_REG;
      end
      S_RESP:  rsp_valid_d = 1'b1;
      default: ;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      wr_be_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      wr_be_q     <= wr_be_d;
      wr_en_q     <= wr_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign wr_addr   = wr_addr_q;
  assign wr_din    = wr_din_q;
  assign wr_be     = wr_be_q;
  assign wr_en     = wr_en_q;
  assign rd_addr   = rd_addr_q;
  assign rd_en     = rd_en_q;

endmodule
